// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Frames on the wire: HDR0 HDR1 LEN PAYLOAD[LEN] CSUM, where CSUM = LEN + sum(payload) mod 256.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_H0,
      ST_H1,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DRAIN
   } state_e;

   localparam logic [1:0] ERR_CSUM    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_PARITY  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] HDR0_DEFAULT = 8'h55;
   localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

// File: rtl/frame_buf_ram.sv
// Payload buffer: one write port, one synchronous read port with a hold-on-idle
// output register, so the read data stays put while the consumer stalls.
module frame_buf_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // NOTE: the array is deliberately left without reset so it maps onto RAM
   // macros; every location is written before it is read within a frame.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts framed command packets in a UART byte stream, checks LEN and checksum,
// and replays the buffered payload as a valid/ready stream for good frames only.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN        = 64,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter logic [7:0] HDR0           = HDR0_DEFAULT,
   parameter logic [7:0] HDR1           = HDR1_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   output logic       s_tready,
   input  logic       s_perr,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic [7:0] frame_len,
   output logic       frame_ok,
   output logic       err_valid,
   output logic [1:0] err_code
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int PW = AW + 1;
   localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

   state_e        state_q,     state_d;
   logic [7:0]    len_q,       len_d;
   logic [7:0]    sum_q,       sum_d;
   logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [IW-1:0] idle_q,      idle_d;
   logic          m_tvalid_q,  m_tvalid_d;
   logic          m_tlast_q,   m_tlast_d;
   logic [7:0]    frame_len_q, frame_len_d;
   logic          frame_ok_q,  frame_ok_d;
   logic          err_valid_q, err_valid_d;
   logic [1:0]    err_code_q,  err_code_d;

   logic          accept;
   logic          counting;
   logic [PW-1:0] len_p;
   logic          ram_we;
   logic          ram_re;
   logic [7:0]    ram_rdata;

   assign len_p = PW'(len_q);

   frame_buf_ram #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (s_tdata),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      sum_d       = sum_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      m_tvalid_d  = m_tvalid_q;
      m_tlast_d   = m_tlast_q;
      frame_len_d = frame_len_q;
      frame_ok_d  = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;

      s_tready = (state_q != ST_DRAIN);
      accept   = s_tvalid && s_tready;
      counting = state_q inside {ST_H1, ST_LEN, ST_PAYLOAD, ST_CSUM};
      idle_d   = (accept || !counting) ? '0 : idle_q + IW'(1);

      // Parity outranks the byte value; a byte landing on expiry beats the timeout.
      if (counting && accept && s_perr) begin
         state_d     = ST_H0;
         err_valid_d = 1'b1;
         err_code_d  = ERR_PARITY;
      end else if (counting && !accept && idle_q == IDLE_LAST) begin
         state_d     = ST_H0;
         err_valid_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
         idle_d      = '0;
      end else begin
         case (state_q)
            ST_H0: begin
               if (accept && !s_perr && s_tdata == HDR0) state_d = ST_H1;
            end
            ST_H1: begin
               if (accept) begin
                  if (s_tdata == HDR1)      state_d = ST_LEN;
                  else if (s_tdata != HDR0) state_d = ST_H0;
               end
            end
            ST_LEN: begin
               if (accept) begin
                  if (s_tdata == 8'h00 || s_tdata > MAX_LEN_B) begin
                     state_d     = ST_H0;
                     err_valid_d = 1'b1;
                     err_code_d  = ERR_LEN;
                  end else begin
                     len_d    = s_tdata;
                     sum_d    = s_tdata;
                     wr_ptr_d = '0;
                     state_d  = ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  ram_we   = 1'b1;
                  sum_d    = sum_q + s_tdata;
                  wr_ptr_d = wr_ptr_q + PW'(1);
                  if (wr_ptr_d == len_p) state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  if (s_tdata == sum_q) begin
                     frame_ok_d  = 1'b1;
                     frame_len_d = len_q;
                     rd_ptr_d    = '0;
                     state_d     = ST_DRAIN;
                  end else begin
                     state_d     = ST_H0;
                     err_valid_d = 1'b1;
                     err_code_d  = ERR_CSUM;
                  end
               end
            end
            ST_DRAIN: begin
               // The RAM read for the next byte is issued in the same cycle the
               // current one is taken, which keeps the stream bubble-free.
               if (!m_tvalid_q || m_tready) begin
                  if (m_tvalid_q && m_tlast_q) begin
                     m_tvalid_d = 1'b0;
                     m_tlast_d  = 1'b0;
                     state_d    = ST_H0;
                  end else begin
                     ram_re     = 1'b1;
                     rd_ptr_d   = rd_ptr_q + PW'(1);
                     m_tvalid_d = 1'b1;
                     m_tlast_d  = (rd_ptr_q == len_p - PW'(1));
                  end
               end
            end
            default: state_d = ST_H0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_H0;
         len_q       <= '0;
         sum_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         idle_q      <= '0;
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         frame_len_q <= '0;
         frame_ok_q  <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         idle_q      <= idle_d;
         m_tvalid_q  <= m_tvalid_d;
         m_tlast_q   <= m_tlast_d;
         frame_len_q <= frame_len_d;
         frame_ok_q  <= frame_ok_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign m_tdata   = m_tvalid_q ? ram_rdata : 8'h00;
   assign m_tvalid  = m_tvalid_q;
   assign m_tlast   = m_tlast_q;
   assign frame_len = frame_len_q;
   assign frame_ok  = frame_ok_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a frame-level model built on a byte queue
// predicts every output each cycle; literal logs pin the model per scenario.
module tb_uart_frame_parser;
   import uart_frame_pkg::*;

   localparam int MAX_LEN = 64;
   localparam int TMO     = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tready;
   logic       s_perr;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic       m_tlast;
   logic [7:0] frame_len;
   logic       frame_ok;
   logic       err_valid;
   logic [1:0] err_code;

   uart_frame_parser #(
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_perr    (s_perr),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .frame_len (frame_len),
      .frame_ok  (frame_ok),
      .err_valid (err_valid),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- frame-level model ----------------
   logic [7:0] frm[$];   // partial frame: HDR0, HDR1, LEN, payload...
   logic [7:0] dq[$];    // payload still to be drained
   bit         draining, armed, started;
   int         cyc, last_acc;
   logic       e_ok, e_err, e_tvalid, e_tlast, e_ready;
   logic [1:0] e_code;
   logic [7:0] e_tdata, e_len;

   task automatic model_abort(input logic [1:0] code);
      e_err  = 1'b1;
      e_code = code;
      frm.delete();
   endtask

   always @(posedge clk) begin
      logic       acc;
      logic [7:0] sum_b;
      if (rst) begin
         frm.delete(); dq.delete();
         draining = 0; armed = 0; started = 1; cyc = 0; last_acc = 0;
         e_ok = 0; e_err = 0; e_code = 0; e_tvalid = 0; e_tdata = 0;
         e_tlast = 0; e_ready = 1; e_len = 0;
      end else begin
         cyc++;
         acc   = s_tvalid && !draining;
         e_ok  = 0;
         e_err = 0;
         if (draining) begin
            if (e_tvalid && m_tready) begin
               void'(dq.pop_front());
               if (dq.size() == 0) draining = 0;
            end
            armed = 1;
         end
         if (acc) begin
            last_acc = cyc;
            if (frm.size() == 0) begin
               if (!s_perr && s_tdata == 8'h55) frm.push_back(s_tdata);
            end else if (s_perr) begin
               model_abort(ERR_PARITY);
            end else if (frm.size() == 1) begin
               if (s_tdata == 8'hAA) frm.push_back(s_tdata);
               else if (s_tdata != 8'h55) frm.delete();
            end else if (frm.size() == 2) begin
               if (s_tdata == 0 || int'(s_tdata) > MAX_LEN) model_abort(ERR_LEN);
               else frm.push_back(s_tdata);
            end else if (frm.size() < 3 + int'(frm[2])) begin
               frm.push_back(s_tdata);
            end else begin
               sum_b = 8'h00;
               for (int i = 2; i < frm.size(); i++) sum_b = sum_b + frm[i];
               if (sum_b == s_tdata) begin
                  e_ok  = 1;
                  e_len = frm[2];
                  for (int i = 3; i < frm.size(); i++) dq.push_back(frm[i]);
                  draining = 1;
                  armed    = 0;
                  frm.delete();
               end else begin
                  model_abort(ERR_CSUM);
               end
            end
         end else if (frm.size() > 0 && cyc - last_acc >= TMO) begin
            model_abort(ERR_TIMEOUT);
         end
         e_ready  = !draining;
         e_tvalid = draining && armed;
         e_tdata  = (dq.size() > 0) ? dq[0] : 8'h00;
         e_tlast  = (dq.size() == 1);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         check("s_tready", s_tready, e_ready);
         check("frame_ok", frame_ok, e_ok);
         check("err_valid", err_valid, e_err);
         if (e_err) check("err_code", err_code, e_code);
         check("m_tvalid", m_tvalid, e_tvalid);
         if (e_tvalid) begin
            check("m_tdata", m_tdata, e_tdata);
            check("m_tlast", m_tlast, e_tlast);
         end
         check("frame_len", frame_len, e_len);
      end
   end

   // ---------------- observed logs for literal checks ----------------
   logic [7:0] got_q[$];
   logic [1:0] got_err[$];
   int         got_ok;

   always @(negedge clk) begin
      if (m_tvalid && m_tready) got_q.push_back(m_tdata);
      if (err_valid) got_err.push_back(err_code);
      if (frame_ok) got_ok++;
   end

   task automatic clear_logs();
      got_q.delete(); got_err.delete(); got_ok = 0;
   endtask

   task automatic check_bytes(input string name, input int n, input logic [31:0] exp);
      check({name, " count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) check(name, got_q[i], exp[8*i +: 8]);
   endtask

   task automatic check_errs(input string name, input int n, input logic [7:0] codes, input int oks);
      check({name, " err count"}, got_err.size(), n);
      for (int i = 0; i < n && i < got_err.size(); i++) check({name, " code"}, got_err[i], codes[2*i +: 2]);
      check({name, " ok count"}, got_ok, oks);
   endtask

   // ---------------- stimulus ----------------
   bit pat_en = 0;
   int pat_k  = 0;

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (pat_en) begin
            m_tready = (pat_k % 4 == 0) || (pat_k % 4 == 3);
            pat_k++;
         end else begin
            m_tready = 1'b1;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [7:0] b, input logic perr = 1'b0);
      logic ok;
      ok       = 1'b0;
      s_tdata  = b;
      s_perr   = perr;
      s_tvalid = 1'b1;
      for (int n = 0; n < 400; n++) begin
         ok = s_tready;
         @(posedge clk); #1;
         if (ok) break;
      end
      if (!ok) check("send timeout", 32'd0, 32'd1);
      s_tvalid = 1'b0;
      s_perr   = 1'b0;
   endtask

   task automatic send_good_3();
      send(8'h55); send(8'hAA); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33); send(8'h69);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_perr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset m_tvalid", m_tvalid, 0);
      check("reset m_tdata", m_tdata, 0);
      check("reset err_code", err_code, 0);
      check("reset frame_len", frame_len, 0);
      check("reset s_tready", s_tready, 1);
      idle(2);

      // 1: basic good frame
      clear_logs();
      send_good_3(); idle(8);
      check_bytes("t1 payload", 3, 32'h0033_2211);
      check_errs("t1", 0, 8'h00, 1);

      // 2: bad checksum, then a good frame
      clear_logs();
      send(8'h55); send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
      idle(3);
      check_bytes("t2 no payload", 0, 32'h0);
      send_good_3(); idle(8);
      check_bytes("t2 recovery payload", 3, 32'h0033_2211);
      check_errs("t2", 1, {6'b0, ERR_CSUM}, 1);

      // 3: repeated header byte, then LEN = 0 and LEN = MAX_LEN+1
      clear_logs();
      send(8'h55); send(8'h55); send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
      idle(6);
      send(8'h55); send(8'hAA); send(8'h00);
      send(8'h55); send(8'hAA); send(8'h41);
      idle(3);
      check_bytes("t3 payload", 1, 32'h0000_007F);
      check_errs("t3", 2, {4'b0, ERR_LEN, ERR_LEN}, 1);

      // 4: parity mid-frame aborts; parity on a would-be header in H0 is ignored
      clear_logs();
      send(8'h55); send(8'hAA); send(8'h02); send(8'h01, 1'b1); send(8'h02); send(8'h03);
      send(8'h55, 1'b1); send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
      idle(3);
      check_errs("t4", 1, {6'b0, ERR_PARITY}, 0);

      // 5: byte exactly on expiry survives; a longer gap times out
      clear_logs();
      send(8'h55); send(8'hAA); send(8'h02); send(8'h01);
      idle(TMO - 1);
      send(8'h02); send(8'h05);
      idle(6);
      check_bytes("t5 payload", 2, 32'h0000_0201);
      send(8'h55); send(8'hAA); send(8'h02); send(8'h01);
      idle(TMO + 5);
      check_errs("t5", 1, {6'b0, ERR_TIMEOUT}, 1);

      // 6: 64-byte frame, stalled drain, reset partway through
      clear_logs();
      send(8'h55); send(8'hAA); send(8'h40);
      for (int i = 0; i < 64; i++) send(8'(i));
      pat_en = 1;
      send(8'h20);
      for (int n = 0; n < 500 && got_q.size() < 20; n++) idle(1);
      check("t6 drained >= 20", 32'(got_q.size() >= 20), 1);
      for (int i = 0; i < 20 && i < got_q.size(); i++) check("t6 payload", got_q[i], i);
      rst = 1'b1;
      idle(1);
      check("t6 m_tvalid after rst", m_tvalid, 0);
      check("t6 state after rst", 32'(dut.state_q == ST_H0), 1);
      rst = 1'b0;
      pat_en = 0;
      idle(2);
      clear_logs();
      send_good_3(); idle(8);
      check_bytes("t6 post-reset payload", 3, 32'h0033_2211);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Downstream consumer of the UART receive byte stream (data_out/data_out_valid/data_out_ready/check_flag). Hunts for framed command packets, which are laid out as 0x55 0xAA LEN PAYLOAD[LEN] CSUM. Buffers the payload and verifies the checksum. Releases the payload as a valid/ready stream only for good frames, and reports per-frame error pulses.

Parameters:
MAX_LEN, 64, largest legal LEN value; also the payload buffer depth.
TIMEOUT_CYCLES, 50000, maximum idle clocks between accepted bytes inside a frame (about 10 byte times at 50 MHz / 115200 baud).
HDR0, 8'h55, first header byte.
HDR1, 8'hAA, second header byte.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
s_tdata  in  8  received byte, from UART data_out.
s_tvalid  in  1  byte valid, from UART data_out_valid.
s_tready  out  1  byte accept, to UART data_out_ready.
s_perr  in  1  parity error for the current byte, from UART check_flag; qualified by s_tvalid.
m_tdata  out  8  payload byte.
m_tvalid  out  1  payload byte valid.
m_tready  in  1  downstream accept.
m_tlast  out  1  marks the last payload byte of a frame.
frame_len  out  8  LEN of the frame being drained; stable while draining.
frame_ok  out  1  one-cycle pulse when a frame passes its checksum.
err_valid  out  1  one-cycle pulse when a frame is aborted.
err_code  out  2  abort cause, valid with err_valid: 0 = checksum, 1 = length, 2 = parity, 3 = timeout.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high on rst.
- Reset values: state = H0; m_tvalid, m_tlast, frame_ok, err_valid = 0; m_tdata, frame_len, err_code = 0; s_tready = 1 one cycle after reset is released.
- Handshake: a byte is accepted on a cycle with s_tvalid && s_tready. A payload byte is transferred on m_tvalid && m_tready.
- Output stability: m_tdata, m_tlast and m_tvalid hold steady while m_tvalid && !m_tready.
- s_tready is 1 in every state except DRAIN, where it is 0 so the UART RX FIFO absorbs backpressure.
- State machine, with transitions evaluated on accepted bytes:
  - H0: byte == HDR0 -> H1; otherwise stay in H0. Bytes with s_perr set are ignored here, with no error pulse.
  - H1: byte == HDR1 -> LEN. byte == HDR0 -> stay in H1. Any other byte -> H0.
  - LEN: LEN == 0 or LEN > MAX_LEN -> err code 1, go to H0. Otherwise latch the length, set sum = LEN and wr_ptr = 0, go to PAYLOAD.
  - PAYLOAD: write the byte to buf[wr_ptr], sum += byte (mod 256), wr_ptr++. After LEN bytes have been written -> CSUM.
  - CSUM: byte == sum -> frame_ok pulse, frame_len = LEN, go to DRAIN. Otherwise err code 0, go to H0.
  - DRAIN: output buf[0..LEN-1] in order, with m_tlast on the final byte. When that final byte is transferred -> H0.
- Parity: s_perr on any accepted byte while in H1, LEN, PAYLOAD or CSUM -> err code 2, go to H0. This check takes priority over the byte's value.
- Timeout:
  - An idle counter clears on every accepted byte and counts only in states H1, LEN, PAYLOAD and CSUM.
  - When it reaches TIMEOUT_CYCLES-1 -> err code 3, go to H0.
  - If a byte arrives in the same cycle the counter expires, the byte wins: it is processed normally and the counter clears.
- Error pulses: err_valid and frame_ok are registered and asserted for exactly one cycle, the cycle after the causing byte is accepted. At most one of them fires per frame.
- Latency:
  - frame_ok is high in the cycle after the CSUM byte is accepted.
  - m_tvalid rises one cycle later (buffer read is synchronous, output register is prefetched). Total latency is 2 cycles from the CSUM byte to the first m_tvalid.
  - With m_tready held high, one byte transfers per cycle with no bubbles. The read address advances when (!m_tvalid || m_tready).
- Reset mid-operation: any state, including partway through DRAIN, returns to H0 and m_tvalid drops in the next cycle. Buffer contents need no clearing.
- Widths: sum is 8-bit with wrap. wr_ptr and rd_ptr are clog2(MAX_LEN)+1 bits wide so that a count of MAX_LEN is representable.

Decomposition:
- Shared package uart_frame_pkg: state enum (H0, H1, LEN, PAYLOAD, CSUM, DRAIN), err_code constants (ERR_CSUM, ERR_LEN, ERR_PARITY, ERR_TIMEOUT), and default HDR0/HDR1.
- One sub-module, frame_buf_ram: single-write, single-read, synchronous-read RAM of MAX_LEN x 8.

Test Plan:
1. Byte stream 55 AA 03 11 22 33 69 with m_tready=1 -> frame_ok pulses once; m_tdata = 11, 22, 33 on consecutive cycles, m_tlast on 33; frame_len = 3.
2. Byte stream 55 AA 02 10 20 31 (correct sum is 32) -> err_valid with err_code 0; no m_tvalid; the parser then accepts a following good frame.
3. Byte stream 55 55 AA 01 7F 80 (repeated header byte), then 55 AA 00 and 55 AA 41 with MAX_LEN = 64 -> the first frame passes with payload 7F; the second and third each give err_code 1.
4. Frame 55 AA 02 01 02 03 with s_perr set on byte 01 -> err_code 2, abort, back to hunting for a header.
5. Stream 55 AA 02 01, then idle for TIMEOUT_CYCLES -> err_code 3 pulses. A byte landing exactly on expiry keeps the frame alive.
6. Good frame of 64 bytes with m_tready toggling 1 0 0 1 -> m_tdata/m_tlast hold steady while stalled; s_tready stays 0 throughout DRAIN; assert rst mid-drain -> m_tvalid is 0 in the next cycle and the state is H0.
